bsr_meta_buffer: RTL and testbench

- On-chip BSR metadata store. Sits directly upstream of the BSR scheduler and serves its metadata read port.
- Loaded once per layer from a DMA word stream: header, then row_ptr table, then col_idx table.
- Validates the tables while loading, then answers single-cycle-latency reads.
- Memory map seen by the scheduler: row_ptr[k] at address k; col_idx[b] at COL_BASE+b.

---
 rtl/bsr_meta_buffer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_bsr_meta_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_meta_buffer.sv
// bsr_meta_buffer: on-chip BSR metadata store feeding the BSR scheduler.
// Loads header / row_ptr / col_idx from a DMA word stream, validates the
// tables while loading, then serves single-cycle-latency metadata reads.
// Optional build macro: META_PARITY_EN (per-word even parity + sticky par_err).
module bsr_meta_buffer #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned COL_BASE  = 128,
    parameter int unsigned NT_W      = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_start,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [31:0]     ld_data,
    input  logic            ld_last,
    input  logic [NT_W-1:0] NT,
    input  logic            meta_ren,
    input  logic [31:0]     meta_raddr,
    output logic [31:0]     meta_rdata,
    output logic            meta_rvalid,
    output logic            meta_ready,
    output logic            loaded,
    output logic            err,
    output logic [2:0]      err_code,
    output logic [15:0]     kt_out,
`ifdef META_PARITY_EN
    output logic [15:0]     nnz_out,
    output logic            par_err
`else
    output logic [15:0]     nnz_out
`endif
);

    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
`ifdef META_PARITY_EN
    localparam int unsigned WORD_W = 33;
`else
    localparam int unsigned WORD_W = 32;
`endif

    localparam logic [2:0] E_NONE   = 3'd0;
    localparam logic [2:0] E_HDR    = 3'd1;
    localparam logic [2:0] E_ORDER  = 3'd2;
    localparam logic [2:0] E_NNZ    = 3'd3;
    localparam logic [2:0] E_COL    = 3'd4;
    localparam logic [2:0] E_LAST   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ROWPTR,
        S_COLIDX,
        S_READY,
        S_ERR
    } state_t;

    // state and datapath registers
    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [31:0]         r_prev;
    logic                r_sink_done;
    logic [15:0]         r_kt;
    logic [15:0]         r_nnz;
    logic                r_err;
    logic [2:0]          r_err_code;
    logic                r_ld_ready;
    logic                r_meta_ready;
    logic                r_loaded;
    logic [31:0]         r_rdata;
    logic                r_rvalid;
    logic [WORD_W-1:0]   r_mem [MEM_DEPTH];

    // next-state / decode wires
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic [31:0]         w_prev_nxt;
    logic                w_sink_nxt;
    logic [15:0]         w_kt_nxt;
    logic [15:0]         w_nnz_nxt;
    logic                w_err_nxt;
    logic [2:0]          w_code_nxt;
    logic [2:0]          w_code;
    logic                w_final;
    logic                w_ld_ready_nxt;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [WORD_W-1:0]   w_wword;
    logic                w_xfer;
    logic                w_hdr_bad;
    logic                w_at_kt;
    logic                w_col_final;
    logic                w_rd_acc;
    logic                w_rd_in_range;
    logic [WORD_W-1:0]   w_rd_word;

    assign w_xfer        = ld_valid && r_ld_ready;
    assign w_hdr_bad     = (ld_data[15:0] == 16'd0)
                        || ((17'(ld_data[15:0]) + 17'd1) > 17'(COL_BASE))
                        || (32'(ld_data[31:16]) > 32'(MEM_DEPTH - COL_BASE));
    assign w_at_kt       = (16'(r_cnt) == r_kt);
    assign w_col_final   = (16'(r_cnt) == (r_nnz - 16'd1));
    assign w_rd_acc      = meta_ren && r_meta_ready;
    assign w_rd_in_range = (meta_raddr < 32'(MEM_DEPTH));
    assign w_rd_word     = r_mem[meta_raddr[ADDR_W-1:0]];

`ifdef META_PARITY_EN
    assign w_wword = {^ld_data, ld_data};
`else
    assign w_wword = ld_data;
`endif

    // load FSM: next state, table checks, memory write strobe
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_prev_nxt  = r_prev;
        w_sink_nxt  = r_sink_done;
        w_kt_nxt    = r_kt;
        w_nnz_nxt   = r_nnz;
        w_err_nxt   = r_err;
        w_code_nxt  = r_err_code;
        w_code      = E_NONE;
        w_final     = 1'b0;
        w_we        = 1'b0;
        w_waddr     = '0;

        if (ld_start) begin
            w_state_nxt = S_HDR;
            w_cnt_nxt   = '0;
            w_sink_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_code_nxt  = E_NONE;
        end else if (w_xfer) begin
            unique case (r_state)
                S_HDR: begin
                    w_kt_nxt  = ld_data[15:0];
                    w_nnz_nxt = ld_data[31:16];
                    // a valid header always has row_ptr words behind it
                    if (w_hdr_bad) begin
                        w_code = E_HDR;
                    end else if (ld_last) begin
                        w_code = E_LAST;
                    end else begin
                        w_state_nxt = S_ROWPTR;
                        w_cnt_nxt   = '0;
                    end
                end
                S_ROWPTR: begin
                    w_we       = 1'b1;
                    w_waddr    = r_cnt;
                    w_prev_nxt = ld_data;
                    w_final    = w_at_kt && (r_nnz == 16'd0);
                    if (((r_cnt == '0) && (ld_data != 32'd0))
                        || ((r_cnt != '0) && (ld_data < r_prev))) begin
                        w_code = E_ORDER;
                    end else if (w_at_kt && (ld_data != 32'(r_nnz))) begin
                        w_code = E_NNZ;
                    end else if (ld_last != w_final) begin
                        w_code = E_LAST;
                    end else if (w_at_kt) begin
                        w_state_nxt = (r_nnz == 16'd0) ? S_READY : S_COLIDX;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + ADDR_W'(1);
                    end
                end
                S_COLIDX: begin
                    w_we    = 1'b1;
                    w_waddr = ADDR_W'(COL_BASE) + r_cnt;
                    w_final = w_col_final;
                    if (ld_data >= 32'(NT)) begin
                        w_code = E_COL;
                    end else if (ld_last != w_final) begin
                        w_code = E_LAST;
                    end else if (w_final) begin
                        w_state_nxt = S_READY;
                    end else begin
                        w_cnt_nxt = r_cnt + ADDR_W'(1);
                    end
                end
                S_ERR: begin
                    if (ld_last) begin
                        w_sink_nxt = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // first error only; the stream is then sunk up to its last word
            if (w_code != E_NONE) begin
                w_state_nxt = S_ERR;
                w_err_nxt   = 1'b1;
                w_code_nxt  = w_code;
                w_sink_nxt  = ld_last;
            end
        end

        w_ld_ready_nxt = (w_state_nxt == S_HDR) || (w_state_nxt == S_ROWPTR)
                      || (w_state_nxt == S_COLIDX)
                      || ((w_state_nxt == S_ERR) && !w_sink_nxt);
    end

    // load FSM state register and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_sink_done  <= 1'b0;
            r_kt         <= '0;
            r_nnz        <= '0;
            r_err        <= 1'b0;
            r_err_code   <= E_NONE;
            r_ld_ready   <= 1'b0;
            r_meta_ready <= 1'b0;
            r_loaded     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_prev       <= w_prev_nxt;
            r_sink_done  <= w_sink_nxt;
            r_kt         <= w_kt_nxt;
            r_nnz        <= w_nnz_nxt;
            r_err        <= w_err_nxt;
            r_err_code   <= w_code_nxt;
            r_ld_ready   <= w_ld_ready_nxt;
            r_meta_ready <= (w_state_nxt == S_READY);
            r_loaded     <= (w_state_nxt == S_READY);
        end
    end

    // metadata RAM write port (contents are not reset)
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wword;
        end
    end

    // read response: one-cycle valid pulse, data held until next accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rdata <= w_rd_in_range ? w_rd_word[31:0] : 32'h0;
            end
        end
    end

`ifdef META_PARITY_EN
    logic r_par_err;

    // sticky parity error, raised together with the offending read's rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if (ld_start) begin
            r_par_err <= 1'b0;
        end else if (w_rd_acc && w_rd_in_range && (^w_rd_word)) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`endif

    assign ld_ready    = r_ld_ready;
    assign meta_rdata  = r_rdata;
    assign meta_rvalid = r_rvalid;
    assign meta_ready  = r_meta_ready;
    assign loaded      = r_loaded;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign kt_out      = r_kt;
    assign nnz_out     = r_nnz;

endmodule

// File: tb/tb_bsr_meta_buffer.sv
// Directed self-checking bench for bsr_meta_buffer.
// Build with META_PARITY_EN defined to also cover the parity path.
module tb_bsr_meta_buffer;

    logic        clk;
    logic        rst_n;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic [9:0]  NT;
    logic        meta_ren;
    logic [31:0] meta_raddr;
    logic [31:0] meta_rdata;
    logic        meta_rvalid;
    logic        meta_ready;
    logic        loaded;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] kt_out;
    logic [15:0] nnz_out;
`ifdef META_PARITY_EN
    logic        par_err;
`endif

    int n_chk = 0;
    int n_bad = 0;

    bsr_meta_buffer #(
        .MEM_DEPTH (1024),
        .COL_BASE  (128),
        .NT_W      (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .NT          (NT),
        .meta_ren    (meta_ren),
        .meta_raddr  (meta_raddr),
        .meta_rdata  (meta_rdata),
        .meta_rvalid (meta_rvalid),
        .meta_ready  (meta_ready),
        .loaded      (loaded),
        .err         (err),
        .err_code    (err_code),
        .kt_out      (kt_out),
`ifdef META_PARITY_EN
        .nnz_out     (nnz_out),
        .par_err     (par_err)
`else
        .nnz_out     (nnz_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        ld_start = 1'b1;
        @(posedge clk);
        #1 ld_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        bit done;
        done = 1'b0;
        @(negedge clk);
        ld_data  = d;
        ld_last  = last;
        ld_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (ld_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (!done) chk("ld_accept_timeout", 32'(ld_ready), 32'd1);
    endtask

    task automatic read1(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        meta_ren   = 1'b1;
        meta_raddr = addr;
        @(negedge clk);
        meta_ren = 1'b0;
        chk({tag, "_rvalid"}, 32'(meta_rvalid), 32'd1);
        chk({tag, "_rdata"}, meta_rdata, exp);
    endtask

    task automatic read_ignored(input string tag);
        @(negedge clk);
        meta_ren   = 1'b1;
        meta_raddr = 32'd1;
        @(negedge clk);
        meta_ren = 1'b0;
        chk({tag, "_rvalid"}, 32'(meta_rvalid), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ld_start   = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;
        NT         = 10'd8;
        meta_ren   = 1'b0;
        meta_raddr = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_meta_ready", 32'(meta_ready), 32'd0);
        chk("rst_rvalid", 32'(meta_rvalid), 32'd0);
        chk("rst_kt_nnz", {nnz_out, kt_out}, 32'd0);
        rst_n = 1'b1;

        // basic load: kt=2 nnz=3, row_ptr 0,2,3, col_idx 1,4,0
        start_load();
        @(negedge clk);
        chk("hdr_ld_ready", 32'(ld_ready), 32'd1);
        send(32'h0003_0002, 1'b0);
        send(32'd0, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd1, 1'b0);
        send(32'd4, 1'b0);
        send(32'd0, 1'b1);
        @(negedge clk);
        chk("a_loaded", 32'(loaded), 32'd1);
        chk("a_err", 32'(err), 32'd0);
        chk("a_meta_ready", 32'(meta_ready), 32'd1);
        chk("a_ld_ready", 32'(ld_ready), 32'd0);
        chk("a_kt", 32'(kt_out), 32'd2);
        chk("a_nnz", 32'(nnz_out), 32'd3);
        read1("a_rd1", 32'd1, 32'd2);
        @(negedge clk);
        chk("a_rvalid_pulse", 32'(meta_rvalid), 32'd0);
        chk("a_rdata_hold", meta_rdata, 32'd2);
        read1("a_rd129", 32'd129, 32'd4);
        read1("a_rd130", 32'd130, 32'd0);

        // back-to-back reads 0,1,2
        @(negedge clk);
        meta_ren   = 1'b1;
        meta_raddr = 32'd0;
        @(negedge clk);
        chk("b2b0_rvalid", 32'(meta_rvalid), 32'd1);
        chk("b2b0_rdata", meta_rdata, 32'd0);
        meta_raddr = 32'd1;
        @(negedge clk);
        chk("b2b1_rvalid", 32'(meta_rvalid), 32'd1);
        chk("b2b1_rdata", meta_rdata, 32'd2);
        meta_raddr = 32'd2;
        @(negedge clk);
        meta_ren = 1'b0;
        chk("b2b2_rvalid", 32'(meta_rvalid), 32'd1);
        chk("b2b2_rdata", meta_rdata, 32'd3);
        @(negedge clk);
        chk("b2b_end_rvalid", 32'(meta_rvalid), 32'd0);
        read1("oor_rd", 32'd2000, 32'd0);

        // row_ptr not monotonic -> code 2, then sink until ld_last
        start_load();
        @(negedge clk);
        chk("restart_loaded", 32'(loaded), 32'd0);
        send(32'h0003_0002, 1'b0);
        send(32'd0, 1'b0);
        send(32'd3, 1'b0);
        send(32'd2, 1'b0);
        @(negedge clk);
        chk("e2_err", 32'(err), 32'd1);
        chk("e2_code", 32'(err_code), 32'd2);
        chk("e2_ld_ready", 32'(ld_ready), 32'd1);
        chk("e2_meta_ready", 32'(meta_ready), 32'd0);
        send(32'd7, 1'b0);
        @(negedge clk);
        chk("e2_sink_ready", 32'(ld_ready), 32'd1);
        send(32'd9, 1'b1);
        @(negedge clk);
        chk("e2_sunk_ready", 32'(ld_ready), 32'd0);
        chk("e2_code_keep", 32'(err_code), 32'd2);
        read_ignored("e2_rd");

        // header checks -> code 1
        start_load();
        send(32'h0001_0000, 1'b0);
        @(negedge clk);
        chk("e1_kt0_code", 32'(err_code), 32'd1);
        chk("e1_kt0_hdr", {nnz_out, kt_out}, 32'h0001_0000);
        start_load();
        send(32'h0381_0001, 1'b0);
        @(negedge clk);
        chk("e1_nnz_code", 32'(err_code), 32'd1);
        start_load();
        send(32'h0000_0080, 1'b0);
        @(negedge clk);
        chk("e1_kt128_code", 32'(err_code), 32'd1);

        // nnz=0: straight to ready after row_ptr
        start_load();
        send(32'h0000_0001, 1'b0);
        send(32'd0, 1'b0);
        send(32'd0, 1'b1);
        @(negedge clk);
        chk("z_loaded", 32'(loaded), 32'd1);
        chk("z_err", 32'(err), 32'd0);
        chk("z_nnz", 32'(nnz_out), 32'd0);

        // same stream without ld_last -> code 5
        start_load();
        send(32'h0000_0001, 1'b0);
        send(32'd0, 1'b0);
        send(32'd0, 1'b0);
        @(negedge clk);
        chk("z5_loaded", 32'(loaded), 32'd0);
        chk("z5_code", 32'(err_code), 32'd5);
        chk("z5_ld_ready", 32'(ld_ready), 32'd1);

        // early ld_last -> code 5, no further words accepted
        start_load();
        send(32'h0001_0001, 1'b0);
        send(32'd0, 1'b1);
        @(negedge clk);
        chk("early_code", 32'(err_code), 32'd5);
        chk("early_ld_ready", 32'(ld_ready), 32'd0);

        // col_idx == NT -> code 4 on a last-word transfer
        start_load();
        send(32'h0002_0001, 1'b0);
        send(32'd0, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd8, 1'b1);
        @(negedge clk);
        chk("e4_code", 32'(err_code), 32'd4);
        chk("e4_err", 32'(err), 32'd1);
        chk("e4_ld_ready", 32'(ld_ready), 32'd0);

        // ld_start clears error, valid reload
        start_load();
        @(negedge clk);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_code", 32'(err_code), 32'd0);
        chk("clr_ld_ready", 32'(ld_ready), 32'd1);
        send(32'h0002_0001, 1'b0);
        send(32'd0, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd7, 1'b1);
        @(negedge clk);
        chk("r_loaded", 32'(loaded), 32'd1);
        read1("r_rd128", 32'd128, 32'd3);
        read1("r_rd129", 32'd129, 32'd7);

`ifdef META_PARITY_EN
        read1("p_rd0", 32'd0, 32'd0);
        chk("p_clean", 32'(par_err), 32'd0);
        @(negedge clk);
        dut.r_mem[1] = dut.r_mem[1] ^ 33'h1;
        @(negedge clk);
        meta_ren   = 1'b1;
        meta_raddr = 32'd1;
        @(negedge clk);
        meta_ren = 1'b0;
        chk("p_rvalid", 32'(meta_rvalid), 32'd1);
        chk("p_par_err", 32'(par_err), 32'd1);
        chk("p_rdata", meta_rdata, 32'd3);
`endif

        // reset in the middle of col_idx loading
        start_load();
        send(32'h0003_0002, 1'b0);
        send(32'd0, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd1, 1'b0);
        @(negedge clk);
        chk("mid_ld_ready", 32'(ld_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_ld_ready", 32'(ld_ready), 32'd0);
        chk("mr_kt_nnz", {nnz_out, kt_out}, 32'd0);
        chk("mr_status", {28'd0, loaded, err, meta_ready, meta_rvalid}, 32'd0);
        chk("mr_rdata", meta_rdata, 32'd0);
`ifdef META_PARITY_EN
        chk("mr_par_err", 32'(par_err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ld_ready", 32'(ld_ready), 32'd0);
        read_ignored("post_rst_rd");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
